gio_input_capture: RTL and testbench
====================================

Name: gio_input_capture

Overview:
- Input-side companion to the display path: conditions the 8 raw GIO_pins (paddle buttons/switches) before the CPU or BRAM uses them.
- Pipeline per pin: 2-flop synchronize -> debounce -> sticky rising-edge flags.
- CPU reads through a one-cycle-latency read port.
- Debounced state changes are pushed into a fixed BRAM/MMIO word through a req/ack write handshake, so the CPU and the hex display path see a stable copy.

Parameters:
WIDTH, 8, number of GIO pins handled
DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronized bit must differ from its stable value before the stable value updates (min 2)
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1
MMIO_ADDR, 16'hFFF0, BRAM word address that receives debounced pin state

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
GIO_pins  input  WIDTH  raw asynchronous pin inputs
rd_en  input  1  CPU read strobe, one cycle
rd_data  output  16  {rise_flags[7:0], stable[7:0]}, valid the cycle after rd_en
rd_valid  output  1  high for exactly one cycle, the cycle after rd_en
wr_req  output  1  BRAM write request, held until acknowledged
wr_addr  output  16  equals MMIO_ADDR whenever wr_req=1
wr_data  output  16  {change_count[7:0], snapshot[7:0]}, constant while wr_req=1
wr_ack  input  1  BRAM side accepts the write in any cycle it is high together with wr_req
change_count  output  8  number of debounced state changes; wraps 255->0

Behaviour:
- Reset (async, active-high): all flops clear; sync stages, stable, counters, rise_flags, change_count, rd_data, rd_valid, wr_req, wr_data and pending all go to 0; wr_addr=MMIO_ADDR; FSM enters IDLE. Reset asserted mid-handshake drops wr_req immediately and discards any pending write.
- Synchronizer: two flops per bit. sync[i] lags GIO_pins[i] by 2 clocks.
- Debounce, per bit, independent:
  - sync==stable: counter<=0.
  - sync!=stable and counter<DEBOUNCE_CYCLES-1: counter+1.
  - sync!=stable and counter==DEBOUNCE_CYCLES-1: stable<=sync, counter<=0.
  - Any glitch back to equality resets the count.
  - Total pin-to-stable latency = 2 + DEBOUNCE_CYCLES clocks.
- change event: any stable bit updates in a cycle. change_count +1 per cycle with an event, not per bit. Two bits updating in the same cycle count once.
- rise_flags[i]: set on a stable[i] 0->1 transition; never set on 1->0.
- Read port:
  - rd_en at cycle N -> rd_data/rd_valid at N+1.
  - rd_data samples rise_flags and stable at N.
  - rise_flags cleared at N+1, except a bit rising in cycle N stays set (set wins over clear).
  - rd_data holds its value between reads.
- Write FSM, states IDLE, REQ:
  - IDLE: on a change event or pending=1 -> REQ. Latch snapshot=stable (post-update value) and change_count (post-increment) into wr_data; assert wr_req; clear pending.
  - REQ: wr_req=1, wr_data frozen.
    - A change event while in REQ sets pending.
    - wr_ack=1 -> drop wr_req, go to IDLE.
    - If pending, IDLE re-enters REQ on the next cycle with a fresh snapshot, so wr_req is low for exactly one cycle between requests.
  - wr_ack while in IDLE is ignored.
  - Change event in the same cycle as wr_ack: pending set, one follow-up write.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, pins=0x00 -> all outputs 0, wr_addr=16'hFFF0, wr_req=0; rd_en gives rd_data=0x0000 with rd_valid one cycle later.
2. Pins 0x00->0x01 held -> stable[0]=1 exactly 6 clocks later; wr_req rises with wr_data=0x0101; wr_ack held 3 cycles low then high -> wr_req drops after the ack cycle; rd_en -> rd_data=0x0101; second rd_en -> 0x0001.
3. Bit 2 pulsed high for 3 cycles, then low -> stable, change_count and wr_req unchanged.
4. Bit 3 rises while a REQ for bit 0 is outstanding (no ack) -> wr_data stays 0x0101 until ack; one cycle of wr_req=0; new request wr_data=0x0209.
5. Bits 4 and 5 both toggle on the same clock -> change_count +1 only; single request with both bits set in the snapshot.
6. Assert reset while wr_req=1 -> wr_req=0 asynchronously. After release, no write is issued until a new change event.

Source files
------------

// File: rtl/gio_input_capture.sv
// -----------------------------------------------------------------------------
// gio_input_capture
//
// Conditions the raw GIO pins (paddle buttons/switches) before the CPU or the
// BRAM/MMIO mirror uses them. Each pin goes through three stages:
//   2-flop synchronizer -> per-bit debounce counter -> sticky rising-edge flag.
// The CPU reads {rise_flags, stable} through a one-cycle-latency read port.
// Every debounced state change is pushed to a fixed BRAM word through a
// req/ack write handshake.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   GIO_pins      raw asynchronous pin inputs [WIDTH]
//   rd_en         CPU read strobe (one cycle)
//   rd_data       {rise_flags[7:0], stable[7:0]}, valid the cycle after rd_en
//   rd_valid      high for one cycle, the cycle after rd_en
//   wr_req        BRAM write request, held until acknowledged
//   wr_addr       BRAM word address (always MMIO_ADDR)
//   wr_data       {change_count[7:0], snapshot[7:0]}, frozen while wr_req=1
//   wr_ack        BRAM accepts the write when high together with wr_req
//   change_count  number of cycles with a debounced state change (wraps)
// -----------------------------------------------------------------------------
module gio_input_capture #(
    parameter int          WIDTH           = 8,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          CNT_W           = 16,
    parameter logic [15:0] MMIO_ADDR       = 16'hFFF0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] GIO_pins,
    input  logic             rd_en,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    output logic             wr_req,
    output logic [15:0]      wr_addr,
    output logic [15:0]      wr_data,
    input  logic             wr_ack,
    output logic [7:0]       change_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t           state;
    logic             pending;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise_flags;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];

    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] rise_set;
    logic             change_evt;
    logic [7:0]       count_nxt;

    // ---------------------------------------------------------------------
    // Debounce decision. A bit updates only after its synchronized value has
    // disagreed with the stable value for DEBOUNCE_CYCLES consecutive cycles;
    // any return to agreement restarts the count.
    // ---------------------------------------------------------------------
    always_comb begin
        update = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    update[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign stable_nxt = stable ^ update;
    assign rise_set   = update & stable_nxt;
    // One count per cycle with any update, regardless of how many bits moved.
    assign change_evt = |update;
    assign count_nxt  = change_count + {7'd0, change_evt};

    // ---------------------------------------------------------------------
    // Synchronizer, debounce state, sticky rise flags, change counter.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            stable       <= '0;
            rise_flags   <= '0;
            change_count <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1        <= GIO_pins;
            sync2        <= sync1;
            stable       <= stable_nxt;
            change_count <= count_nxt;
            // A read clears the flags, but a rise in the same cycle survives.
            rise_flags   <= (rd_en ? '0 : rise_flags) | rise_set;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // CPU read port: one-cycle latency, data held between reads.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= {8'(rise_flags), 8'(stable)};
            end
        end
    end

    // ---------------------------------------------------------------------
    // Write handshake FSM. The snapshot uses the post-update stable value and
    // post-increment count so the mirror matches what the registers hold
    // after the event edge. Events seen while a request is outstanding are
    // folded into a single follow-up write via pending.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wr_req  <= 1'b0;
            wr_data <= '0;
            pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (change_evt || pending) begin
                        state   <= REQ;
                        wr_req  <= 1'b1;
                        wr_data <= {count_nxt, 8'(stable_nxt)};
                        pending <= 1'b0;
                    end
                end
                REQ: begin
                    if (change_evt) begin
                        pending <= 1'b1;
                    end
                    if (wr_ack) begin
                        state  <= IDLE;
                        wr_req <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    wr_req <= 1'b0;
                end
            endcase
        end
    end

    assign wr_addr = MMIO_ADDR;

endmodule

// File: tb/tb_gio_input_capture.sv
// -----------------------------------------------------------------------------
// tb_gio_input_capture
//
// Directed, self-checking bench for gio_input_capture with DEBOUNCE_CYCLES=4,
// so a held pin change reaches the stable register 6 clocks after it is
// applied. Inputs change 1 ns after each rising edge; outputs are observed at
// the same point.
// -----------------------------------------------------------------------------
module tb_gio_input_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  GIO_pins;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [7:0]  change_count;

    int n_cmp = 0;
    int n_bad = 0;

    gio_input_capture #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16),
        .MMIO_ADDR(16'hFFF0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .GIO_pins(GIO_pins),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .change_count(change_count)
    );

    initial forever #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        GIO_pins = 8'h00;
        rd_en    = 1'b0;
        wr_ack   = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL reset_wr_req got=%b exp=0", wr_req); end
        n_cmp++; if (wr_addr !== 16'hFFF0) begin n_bad++; $display("FAIL reset_wr_addr got=%h exp=fff0", wr_addr); end
        n_cmp++; if (wr_data !== 16'h0000) begin n_bad++; $display("FAIL reset_wr_data got=%h exp=0000", wr_data); end
        n_cmp++; if (change_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", change_count); end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL reset_read_valid got=%b exp=1", rd_valid); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL reset_read_data got=%h exp=0000", rd_data); end
        tick(1);
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_read_valid_drop got=%b exp=0", rd_valid); end
    endtask

    task automatic test_single_pin();
        GIO_pins = 8'h01;
        tick(5);
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL pin0_early_req got=%b exp=0", wr_req); end
        n_cmp++; if (change_count !== 8'd0) begin n_bad++; $display("FAIL pin0_early_count got=%0d exp=0", change_count); end
        tick(1);
        n_cmp++; if (wr_req !== 1'b1) begin n_bad++; $display("FAIL pin0_req got=%b exp=1", wr_req); end
        n_cmp++; if (wr_data !== 16'h0101) begin n_bad++; $display("FAIL pin0_wr_data got=%h exp=0101", wr_data); end
        n_cmp++; if (change_count !== 8'd1) begin n_bad++; $display("FAIL pin0_count got=%0d exp=1", change_count); end
        for (int k = 0; k < 3; k++) begin
            tick(1);
            n_cmp++; if (wr_req !== 1'b1 || wr_data !== 16'h0101) begin n_bad++; $display("FAIL pin0_hold got=%b/%h exp=1/0101", wr_req, wr_data); end
        end
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL pin0_ack_drop got=%b exp=0", wr_req); end
        tick(1);
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL pin0_no_rereq got=%b exp=0", wr_req); end
        rd_en = 1'b1;
        tick(1);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0101) begin n_bad++; $display("FAIL pin0_read1 got=%b/%h exp=1/0101", rd_valid, rd_data); end
        tick(1);
        rd_en = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0001) begin n_bad++; $display("FAIL pin0_read2 got=%b/%h exp=1/0001", rd_valid, rd_data); end
        tick(1);
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 16'h0001) begin n_bad++; $display("FAIL pin0_read_hold got=%b/%h exp=0/0001", rd_valid, rd_data); end
    endtask

    task automatic test_glitch();
        int reqs;
        reqs = 0;
        GIO_pins = 8'h05;
        tick(3);
        GIO_pins = 8'h01;
        for (int k = 0; k < 10; k++) begin
            if (wr_req) reqs++;
            tick(1);
        end
        n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL glitch_req cycles=%0d exp=0", reqs); end
        n_cmp++; if (change_count !== 8'd1) begin n_bad++; $display("FAIL glitch_count got=%0d exp=1", change_count); end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        n_cmp++; if (rd_data !== 16'h0001) begin n_bad++; $display("FAIL glitch_stable got=%h exp=0001", rd_data); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        GIO_pins = 8'h01;
        tick(6);
        n_cmp++; if (wr_req !== 1'b1 || wr_data !== 16'h0101) begin n_bad++; $display("FAIL b2b_first got=%b/%h exp=1/0101", wr_req, wr_data); end
        GIO_pins = 8'h09;
        tick(6);
        n_cmp++; if (change_count !== 8'd2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", change_count); end
        n_cmp++; if (wr_req !== 1'b1 || wr_data !== 16'h0101) begin n_bad++; $display("FAIL b2b_frozen got=%b/%h exp=1/0101", wr_req, wr_data); end
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got=%b exp=0", wr_req); end
        tick(1);
        n_cmp++; if (wr_req !== 1'b1 || wr_data !== 16'h0209) begin n_bad++; $display("FAIL b2b_second got=%b/%h exp=1/0209", wr_req, wr_data); end
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        tick(1);
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL b2b_done got=%b exp=0", wr_req); end
    endtask

    task automatic test_simultaneous();
        GIO_pins = 8'h39;
        tick(5);
        n_cmp++; if (change_count !== 8'd2) begin n_bad++; $display("FAIL simul_early_count got=%0d exp=2", change_count); end
        tick(1);
        n_cmp++; if (change_count !== 8'd3) begin n_bad++; $display("FAIL simul_count got=%0d exp=3", change_count); end
        n_cmp++; if (wr_req !== 1'b1 || wr_data !== 16'h0339) begin n_bad++; $display("FAIL simul_req got=%b/%h exp=1/0339", wr_req, wr_data); end
        tick(1);
        n_cmp++; if (change_count !== 8'd3) begin n_bad++; $display("FAIL simul_count_once got=%0d exp=3", change_count); end
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        tick(1);
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL simul_single_req got=%b exp=0", wr_req); end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        n_cmp++; if (rd_data !== 16'h3939) begin n_bad++; $display("FAIL simul_read got=%h exp=3939", rd_data); end
    endtask

    task automatic test_reset_mid_handshake();
        int reqs;
        reqs = 0;
        GIO_pins = 8'h38;
        tick(6);
        n_cmp++; if (wr_req !== 1'b1 || wr_data !== 16'h0438) begin n_bad++; $display("FAIL midrst_req got=%b/%h exp=1/0438", wr_req, wr_data); end
        #2;
        reset    = 1'b1;
        GIO_pins = 8'h00;
        #1;
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL midrst_async got=%b exp=0", wr_req); end
        n_cmp++; if (change_count !== 8'd0) begin n_bad++; $display("FAIL midrst_count got=%0d exp=0", change_count); end
        tick(2);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (wr_req) reqs++;
        end
        n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL midrst_no_write cycles=%0d exp=0", reqs); end
        GIO_pins = 8'h02;
        tick(6);
        n_cmp++; if (wr_req !== 1'b1 || wr_data !== 16'h0102) begin n_bad++; $display("FAIL midrst_new_req got=%b/%h exp=1/0102", wr_req, wr_data); end
    endtask

    task automatic test_ack_with_event();
        // Request 0x0102 is outstanding; the next event lands on the ack edge.
        GIO_pins = 8'h06;
        tick(5);
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL ackevt_drop got=%b exp=0", wr_req); end
        n_cmp++; if (change_count !== 8'd2) begin n_bad++; $display("FAIL ackevt_count got=%0d exp=2", change_count); end
        tick(1);
        n_cmp++; if (wr_req !== 1'b1 || wr_data !== 16'h0206) begin n_bad++; $display("FAIL ackevt_follow got=%b/%h exp=1/0206", wr_req, wr_data); end
        wr_ack = 1'b1;
        tick(1);
        // Ack kept high while idle must not start anything.
        tick(2);
        wr_ack = 1'b0;
        n_cmp++; if (wr_req !== 1'b0 || wr_data !== 16'h0206) begin n_bad++; $display("FAIL ackevt_idle_ack got=%b/%h exp=0/0206", wr_req, wr_data); end
    endtask

    initial begin
        reset    = 1'b1;
        GIO_pins = 8'h00;
        rd_en    = 1'b0;
        wr_ack   = 1'b0;
        test_reset();
        test_single_pin();
        test_glitch();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_handshake();
        test_ack_with_event();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
